// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: FSM state encoding,
// requester identifiers, word/address widths and the WAIT timeout limit.
package mem_access_ctrl_pkg;

    localparam int WORD_W        = 31;
    localparam int ADDR_W        = 12;
    localparam int TMO_W         = 4;
    localparam int TIMEOUT_LIMIT = 15;

    // Counter value seen in the last WAIT cycle before a timeout fires.
    localparam logic [TMO_W-1:0] TMO_LAST = 4'(TIMEOUT_LIMIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ID_PNL  = 2'd0,
        ID_IO   = 2'd1,
        ID_PU   = 2'd2,
        ID_NONE = 2'd3
    } req_id_t;

endpackage

// File: rtl/mem_access_ctrl_prio_arb.sv
// Fixed-priority requester selector: panel > IO > PU.
module mem_prio_arb
    import mem_access_ctrl_pkg::*;
(
    input  logic    pnl_req,
    input  logic    io_req,
    input  logic    pu_req,
    output logic    grant_valid,
    output req_id_t grant_id
);

    // Pick the highest-priority active request.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = ID_NONE;
        if (pnl_req) begin
            grant_valid = 1'b1;
            grant_id    = ID_PNL;
        end else if (io_req) begin
            grant_valid = 1'b1;
            grant_id    = ID_IO;
        end else if (pu_req) begin
            grant_valid = 1'b1;
            grant_id    = ID_PU;
        end else begin
            grant_valid = 1'b0;
            grant_id    = ID_NONE;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: arbitrates PU / panel / IO requests onto a single
// memory port and runs one transaction at a time (IDLE, ISSUE, WAIT, DONE).
// All outputs are registered. Optional feature: define MEM_TIMEOUT_EN to end a
// WAIT after 15 cycles without a matching reply, flagging err with the ack.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              pu_req,
    input  logic [ADDR_W-1:0] pu_addr,
    input  logic              pnl_req,
    input  logic              pnl_we,
    input  logic [ADDR_W-1:0] pnl_addr,
    input  logic [WORD_W-1:0] pnl_wdata,
    input  logic              io_req,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [WORD_W-1:0] io_wdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] sel_value,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_read_reply,
    input  logic              mem_write_reply,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              pu_ack,
    output logic              pnl_ack,
    output logic              io_ack,
    output logic [WORD_W-1:0] rdata,
    output logic              err
);

    state_t            state_r, state_s;
    req_id_t           id_r, id_s;
    logic              we_r, we_s;
    logic [ADDR_W-1:0] sel_value_r, sel_value_s;
    logic [WORD_W-1:0] wdata_r, wdata_s;
    logic [WORD_W-1:0] rdata_r, rdata_s;
    logic              mem_read_r, mem_read_s;
    logic              mem_write_r, mem_write_s;
    logic              pu_ack_r, pu_ack_s;
    logic              pnl_ack_r, pnl_ack_s;
    logic              io_ack_r, io_ack_s;
    logic              err_r, err_s;
    logic [TMO_W-1:0]  tmo_cnt_r, tmo_cnt_s;
    logic              finish_s;
    logic              reply_match_s;
    logic              grant_valid_s;
    req_id_t           grant_id_s;

    mem_prio_arb u_arb (
        .pnl_req     (pnl_req),
        .io_req      (io_req),
        .pu_req      (pu_req),
        .grant_valid (grant_valid_s),
        .grant_id    (grant_id_s)
    );

    // Only the reply matching the latched direction can end a WAIT.
    assign reply_match_s = we_r ? mem_write_reply : mem_read_reply;

    // Next-state and next-output logic; strobes and acks default to idle.
    always_comb begin
        state_s     = state_r;
        id_s        = id_r;
        we_s        = we_r;
        sel_value_s = sel_value_r;
        wdata_s     = wdata_r;
        rdata_s     = rdata_r;
        tmo_cnt_s   = tmo_cnt_r;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        err_s       = 1'b0;
        finish_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    state_s = ST_ISSUE;
                    id_s    = grant_id_s;
                    case (grant_id_s)
                        ID_PNL: begin
                            we_s        = pnl_we;
                            sel_value_s = pnl_addr;
                            wdata_s     = pnl_we ? pnl_wdata : {WORD_W{1'b0}};
                        end
                        ID_IO: begin
                            we_s        = 1'b1;
                            sel_value_s = io_addr;
                            wdata_s     = io_wdata;
                        end
                        ID_PU: begin
                            we_s        = 1'b0;
                            sel_value_s = pu_addr;
                            wdata_s     = {WORD_W{1'b0}};
                        end
                        default: begin
                            we_s        = 1'b0;
                            sel_value_s = {ADDR_W{1'b0}};
                            wdata_s     = {WORD_W{1'b0}};
                        end
                    endcase
                    // Registered so the strobe is high exactly in the ISSUE cycle.
                    mem_read_s  = ~we_s;
                    mem_write_s = we_s;
                end else begin
                    sel_value_s = {ADDR_W{1'b0}};
                    wdata_s     = {WORD_W{1'b0}};
                end
            end
            ST_ISSUE: begin
                state_s   = ST_WAIT;
                tmo_cnt_s = {TMO_W{1'b0}};
            end
            ST_WAIT: begin
                if (reply_match_s) begin
                    finish_s = 1'b1;
                    rdata_s  = we_r ? rdata_r : mem_rdata;
`ifdef MEM_TIMEOUT_EN
                end else if (tmo_cnt_r == TMO_LAST) begin
                    finish_s = 1'b1;
                    err_s    = 1'b1;
                    rdata_s  = we_r ? rdata_r : {WORD_W{1'b0}};
                end else begin
                    tmo_cnt_s = tmo_cnt_r + 4'd1;
                end
`else
                end else begin
                    tmo_cnt_s = tmo_cnt_r;
                end
`endif
                if (finish_s) begin
                    state_s     = ST_DONE;
                    sel_value_s = {ADDR_W{1'b0}};
                    wdata_s     = {WORD_W{1'b0}};
                    tmo_cnt_s   = {TMO_W{1'b0}};
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                // No arbitration here: a still-held request waits for IDLE.
                state_s = ST_IDLE;
            end
            default: begin
                state_s     = ST_IDLE;
                sel_value_s = {ADDR_W{1'b0}};
                wdata_s     = {WORD_W{1'b0}};
                tmo_cnt_s   = {TMO_W{1'b0}};
            end
        endcase
        pnl_ack_s = finish_s && (id_r == ID_PNL);
        io_ack_s  = finish_s && (id_r == ID_IO);
        pu_ack_s  = finish_s && (id_r == ID_PU);
    end

    // State and output registers; reset forces IDLE with every output cleared.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            id_r        <= ID_NONE;
            we_r        <= 1'b0;
            sel_value_r <= {ADDR_W{1'b0}};
            wdata_r     <= {WORD_W{1'b0}};
            rdata_r     <= {WORD_W{1'b0}};
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            pu_ack_r    <= 1'b0;
            pnl_ack_r   <= 1'b0;
            io_ack_r    <= 1'b0;
            err_r       <= 1'b0;
            tmo_cnt_r   <= {TMO_W{1'b0}};
        end else begin
            state_r     <= state_s;
            id_r        <= id_s;
            we_r        <= we_s;
            sel_value_r <= sel_value_s;
            wdata_r     <= wdata_s;
            rdata_r     <= rdata_s;
            mem_read_r  <= mem_read_s;
            mem_write_r <= mem_write_s;
            pu_ack_r    <= pu_ack_s;
            pnl_ack_r   <= pnl_ack_s;
            io_ack_r    <= io_ack_s;
            err_r       <= err_s;
            tmo_cnt_r   <= tmo_cnt_s;
        end
    end

    assign mem_read  = mem_read_r;
    assign mem_write = mem_write_r;
    assign sel_value = sel_value_r;
    assign mem_wdata = wdata_r;
    assign rdata     = rdata_r;
    assign pu_ack    = pu_ack_r;
    assign pnl_ack   = pnl_ack_r;
    assign io_ack    = io_ack_r;
    assign err       = err_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed scoreboard bench for mem_access_ctrl. A background memory model
// answers strobes after a programmable delay; expected completions are queued
// when requests are driven and checked when an ack appears.
module tb_mem_access_ctrl;

    localparam int TB_PNL = 0;
    localparam int TB_IO  = 1;
    localparam int TB_PU  = 2;
    localparam logic [30:0] IDLE_PAT = 31'h2AAA_AAAA;

    typedef struct {
        int          id;
        logic [30:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic        pu_req, pnl_req, pnl_we, io_req;
    logic [11:0] pu_addr, pnl_addr, io_addr;
    logic [30:0] pnl_wdata, io_wdata;
    logic        mem_read, mem_write;
    logic [11:0] sel_value;
    logic [30:0] mem_wdata;
    logic        mem_read_reply, mem_write_reply;
    logic [30:0] mem_rdata;
    logic        pu_ack, pnl_ack, io_ack;
    logic [30:0] rdata;
    logic        err;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    // Memory model knobs and statistics.
    bit          rd_en    = 1'b1;
    int          rd_delay = 2;
    bit          bogus    = 1'b0;
    bit          fixed_en = 1'b0;
    logic [30:0] fixed_data = 31'h0;
    int          n_rd_strobe = 0;
    int          n_wr_strobe = 0;

    mem_access_ctrl dut (
        .clk             (clk),
        .resetn          (resetn),
        .pu_req          (pu_req),
        .pu_addr         (pu_addr),
        .pnl_req         (pnl_req),
        .pnl_we          (pnl_we),
        .pnl_addr        (pnl_addr),
        .pnl_wdata       (pnl_wdata),
        .io_req          (io_req),
        .io_addr         (io_addr),
        .io_wdata        (io_wdata),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .sel_value       (sel_value),
        .mem_wdata       (mem_wdata),
        .mem_read_reply  (mem_read_reply),
        .mem_write_reply (mem_write_reply),
        .mem_rdata       (mem_rdata),
        .pu_ack          (pu_ack),
        .pnl_ack         (pnl_ack),
        .io_ack          (io_ack),
        .rdata           (rdata),
        .err             (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [30:0] mk_word(input logic [11:0] a);
        return {1'b1, 6'h2A, a, ~a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, {26'd0, mem_read, mem_write, pnl_ack, io_ack, pu_ack, err}, 32'd0);
        chk({tag, "_sel"}, {20'd0, sel_value}, 32'd0);
        chk({tag, "_wdata"}, {1'b0, mem_wdata}, 32'd0);
        chk({tag, "_rdata"}, {1'b0, rdata}, 32'd0);
    endtask

    // Wait (bounded) for an ack, release the winner's request and score it.
    task automatic wait_ack(input int elapsed, input int budget);
        int   lat;
        bit   got;
        int   obs_id;
        exp_t e;
        lat = elapsed;
        got = 1'b0;
        while (!got && lat < budget) begin
            @(negedge clk);
            lat++;
            if (pu_ack || pnl_ack || io_ack) got = 1'b1;
        end
        chk("ack_seen", {31'd0, got}, 32'd1);
        if (!got) return;
        chk("ack_onehot", 32'(pnl_ack) + 32'(io_ack) + 32'(pu_ack), 32'd1);
        obs_id = pnl_ack ? TB_PNL : (io_ack ? TB_IO : TB_PU);
        chk("sb_nonempty", {31'd0, sb_q.size() > 0}, 32'd1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        chk("ack_id", obs_id, e.id);
        chk("ack_rdata", {1'b0, rdata}, {1'b0, e.rdata});
        chk("ack_err", {31'd0, err}, {31'd0, e.err});
        chk("done_sel_zero", {20'd0, sel_value}, 32'd0);
        if (e.lat > 0) chk("ack_latency", lat, e.lat);
        case (obs_id)
            TB_PNL:  pnl_req = 1'b0;
            TB_IO:   io_req  = 1'b0;
            default: pu_req  = 1'b0;
        endcase
        @(negedge clk);
        chk("ack_pulse", {29'd0, pnl_ack, io_ack, pu_ack}, 32'd0);
    endtask

    // Memory model: answers each strobe after a delay; state survives DUT reset.
    initial begin
        int          rd_cnt;
        int          wr_cnt;
        int          bog_cnt;
        logic [30:0] rd_word;
        rd_cnt  = 0;
        wr_cnt  = 0;
        bog_cnt = 0;
        rd_word = 31'h0;
        mem_read_reply  = 1'b0;
        mem_write_reply = 1'b0;
        mem_rdata       = IDLE_PAT;
        forever begin
            @(negedge clk);
            mem_read_reply  = 1'b0;
            mem_write_reply = 1'b0;
            mem_rdata       = IDLE_PAT;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    mem_read_reply = 1'b1;
                    mem_rdata      = rd_word;
                end
            end
            if (wr_cnt > 0) begin
                wr_cnt--;
                if (wr_cnt == 0) mem_write_reply = 1'b1;
            end
            if (bog_cnt > 0) begin
                bog_cnt--;
                if (bog_cnt == 0) mem_write_reply = 1'b1;
            end
            if (mem_read === 1'b1) begin
                n_rd_strobe++;
                rd_cnt  = rd_en ? rd_delay : 0;
                bog_cnt = bogus ? 2 : 0;
                rd_word = fixed_en ? fixed_data : mk_word(sel_value);
            end
            if (mem_write === 1'b1) begin
                n_wr_strobe++;
                wr_cnt = 2;
            end
        end
    end

    initial begin
        int rd0, wr0, acks;
        pu_req = 1'b0; pnl_req = 1'b0; pnl_we = 1'b0; io_req = 1'b0;
        pu_addr = 12'h0; pnl_addr = 12'h0; io_addr = 12'h0;
        pnl_wdata = 31'h0; io_wdata = 31'h0;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        resetn = 1'b1;
        @(negedge clk);
        chk_all_zero("post_release");

        // PU read at 0o1234 returning 31'h4000_0005.
        fixed_en = 1'b1; fixed_data = 31'h4000_0005;
        sb_q.push_back('{TB_PU, 31'h4000_0005, 1'b0, 4});
        pu_addr = 12'o1234; pu_req = 1'b1;
        @(negedge clk);
        chk("pu_issue_read", {30'd0, mem_read, mem_write}, 32'd2);
        chk("pu_issue_sel", {20'd0, sel_value}, 32'o1234);
        @(negedge clk);
        chk("pu_wait_strobe", {30'd0, mem_read, mem_write}, 32'd0);
        chk("pu_wait_sel", {20'd0, sel_value}, 32'o1234);
        wait_ack(2, 12);
        fixed_en = 1'b0;

        // Panel write to 0o7777; rdata must keep the previous read word.
        wr0 = n_wr_strobe; rd0 = n_rd_strobe;
        sb_q.push_back('{TB_PNL, 31'h4000_0005, 1'b0, 4});
        pnl_we = 1'b1; pnl_addr = 12'o7777; pnl_wdata = 31'h7FFF_FFFF; pnl_req = 1'b1;
        @(negedge clk);
        chk("pnl_issue_write", {30'd0, mem_read, mem_write}, 32'd1);
        chk("pnl_issue_wdata", {1'b0, mem_wdata}, 32'h7FFF_FFFF);
        chk("pnl_issue_sel", {20'd0, sel_value}, 32'o7777);
        wait_ack(1, 12);
        chk("pnl_write_strobes", n_wr_strobe - wr0, 32'd1);
        chk("pnl_read_strobes", n_rd_strobe - rd0, 32'd0);

        // Three simultaneous held requests: served pnl, io, pu.
        wr0 = n_wr_strobe; rd0 = n_rd_strobe;
        sb_q.push_back('{TB_PNL, mk_word(12'h0A1), 1'b0, 4});
        sb_q.push_back('{TB_IO,  mk_word(12'h0A1), 1'b0, 0});
        sb_q.push_back('{TB_PU,  mk_word(12'hF0F), 1'b0, 0});
        pnl_we = 1'b0; pnl_addr = 12'h0A1; pnl_req = 1'b1;
        io_addr = 12'h3C4; io_wdata = 31'h1234_5678; io_req = 1'b1;
        pu_addr = 12'hF0F; pu_req = 1'b1;
        wait_ack(0, 12);
        wait_ack(0, 12);
        wait_ack(0, 12);
        chk("multi_strobes", (n_wr_strobe - wr0) + (n_rd_strobe - rd0), 32'd3);
        chk("multi_wr_strobes", n_wr_strobe - wr0, 32'd1);
        chk("multi_sb_drained", sb_q.size(), 32'd0);

        // Write reply during a read's WAIT must be ignored.
        rd_delay = 5; bogus = 1'b1;
        sb_q.push_back('{TB_PU, mk_word(12'h555), 1'b0, 7});
        pu_addr = 12'h555; pu_req = 1'b1;
        wait_ack(0, 14);
        rd_delay = 2; bogus = 1'b0;

`ifdef MEM_TIMEOUT_EN
        // Unanswered read: err with ack after 15 WAIT cycles, rdata cleared.
        rd_en = 1'b0;
        sb_q.push_back('{TB_PU, 31'h0, 1'b1, 17});
        pu_addr = 12'h777; pu_req = 1'b1;
        wait_ack(0, 24);
        rd_en = 1'b1;
`else
        // Unanswered read: WAIT persists, no ack and no err.
        rd_en = 1'b0;
        acks = 0;
        pu_addr = 12'h777; pu_req = 1'b1;
        repeat (40) begin
            @(negedge clk);
            acks += int'(pu_ack) + int'(pnl_ack) + int'(io_ack) + int'(err);
        end
        chk("no_timeout_acks", acks, 32'd0);
        pu_req = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        rd_en = 1'b1;
        @(negedge clk);
`endif

        // Ordinary read so rdata holds a nonzero word before the reset test.
        sb_q.push_back('{TB_PU, mk_word(12'h222), 1'b0, 4});
        pu_addr = 12'h222; pu_req = 1'b1;
        wait_ack(0, 12);

        // Reset asserted during WAIT; the late reply lands in IDLE.
        rd_delay = 4;
        pu_addr = 12'h111; pu_req = 1'b1;
        @(negedge clk);
        chk("rst_txn_issue", {31'd0, mem_read}, 32'd1);
        @(negedge clk);
        resetn = 1'b0; pu_req = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        @(negedge clk);
        resetn = 1'b1;
        rd0 = n_rd_strobe; wr0 = n_wr_strobe;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            acks += int'(pu_ack) + int'(pnl_ack) + int'(io_ack);
        end
        chk("late_reply_acks", acks, 32'd0);
        chk("late_reply_strobes", (n_rd_strobe - rd0) + (n_wr_strobe - wr0), 32'd0);
        chk("late_reply_rdata", {1'b0, rdata}, 32'd0);
        rd_delay = 2;

        // Controller recovers: panel write after reset keeps rdata at 0.
        sb_q.push_back('{TB_PNL, 31'h0, 1'b0, 4});
        pnl_we = 1'b1; pnl_addr = 12'h0F0; pnl_wdata = 31'h4ABC_DEF0; pnl_req = 1'b1;
        wait_ack(0, 12);
        chk("final_sb_drained", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
